// File: rtl/dtree_pkg.sv
// Shared widths, defaults and event types for the decision-tree readout path.
package dtree_pkg;

  localparam int DEF_FEATURES    = 3;
  localparam int DEF_LABEL_WIDTH = 4;
  localparam int DEF_TS_WIDTH    = 16;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_DROP_WIDTH  = 8;

  // A single-feature tree still needs one bit of level/path.
  function automatic int leaf_width(input int features);
    return (features < 2) ? 1 : $clog2(features);
  endfunction

  localparam int LW        = leaf_width(DEF_FEATURES);
  localparam int IDX_WIDTH = 2 * LW;

  typedef logic [IDX_WIDTH-1:0] leaf_idx_t;

  typedef struct packed {
    logic [DEF_LABEL_WIDTH-1:0] label;
    logic [DEF_TS_WIDTH-1:0]    timestamp;
  } label_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a DEPTH+1-state occupancy counter and register-array head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same edge, so a full FIFO may still take a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/leaf_label_fifo.sv
// Maps classifier leaves to labels, timestamps them and queues them for readout.
// Define CLASS_COUNT_EN to add per-class accepted-event counters (cnt_sel/cnt_value).
module leaf_label_fifo
  import dtree_pkg::*;
#(
  parameter int FEATURES    = DEF_FEATURES,
  parameter int LABEL_WIDTH = DEF_LABEL_WIDTH,
  parameter int TS_WIDTH    = DEF_TS_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int DROP_WIDTH  = DEF_DROP_WIDTH,
  localparam int LWD        = leaf_width(FEATURES),
  localparam int IDX_W      = 2 * LWD
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef CLASS_COUNT_EN
  input  logic [LABEL_WIDTH-1:0] cnt_sel,
  output logic [TS_WIDTH-1:0]    cnt_value,
`endif
  input  logic [LWD-1:0]         level,
  input  logic [LWD-1:0]         path,
  input  logic                   in_valid,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [LABEL_WIDTH-1:0] cfg_label,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LABEL_WIDTH-1:0] m_label,
  output logic [TS_WIDTH-1:0]    m_timestamp,
  output logic [DROP_WIDTH-1:0]  drop_count,
  output logic                   overflow
);

  localparam int TABLE_SIZE  = 2 ** IDX_W;
  localparam int NUM_CLASSES = 2 ** LABEL_WIDTH;
  localparam int EVT_W       = LABEL_WIDTH + TS_WIDTH;

  logic [TS_WIDTH-1:0]    ts_q;
  logic                   stage_valid_q;
  logic [IDX_W-1:0]       stage_idx_q;
  logic [TS_WIDTH-1:0]    stage_ts_q;
  logic [LABEL_WIDTH-1:0] table_q [TABLE_SIZE];
  logic [DROP_WIDTH-1:0]  drop_q;
  logic                   overflow_q;

  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;
  logic [LABEL_WIDTH-1:0] push_label;
  logic [EVT_W-1:0]       push_data;
  logic [EVT_W-1:0]       head_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q          <= '0;
      stage_valid_q <= 1'b0;
      stage_idx_q   <= '0;
      stage_ts_q    <= '0;
    end else begin
      ts_q          <= ts_q + 1'b1;
      stage_valid_q <= in_valid;
      if (in_valid) begin
        stage_idx_q <= {level, path};
        stage_ts_q  <= ts_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we) begin
      table_q[cfg_addr] <= cfg_label;
    end
  end

  // The table read is combinational from the registers, so a same-cycle write is seen one event later.
  assign push_label = table_q[stage_idx_q];
  assign push_data  = {push_label, stage_ts_q};
  assign push       = stage_valid_q;
  assign pop        = !fifo_empty && m_ready;
  assign drop       = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      if (drop_q != '1) begin
        drop_q <= drop_q + 1'b1;
      end
      overflow_q <= 1'b1;
    end
  end

  assign m_valid                = !fifo_empty;
  assign {m_label, m_timestamp} = head_data;
  assign drop_count             = drop_q;
  assign overflow               = overflow_q;

`ifdef CLASS_COUNT_EN
  logic [TS_WIDTH-1:0] cnt_q [NUM_CLASSES];
  logic [TS_WIDTH-1:0] cnt_value_q;
  logic                accept;

  assign accept    = push && (!fifo_full || pop);
  assign cnt_value = cnt_value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_value_q <= '0;
    end else begin
      if (accept && (cnt_q[push_label] != '1)) begin
        cnt_q[push_label] <= cnt_q[push_label] + 1'b1;
      end
      cnt_value_q <= cnt_q[cnt_sel];
    end
  end
`else
  // Build without class counters: nothing beyond the readout queue.
`endif

endmodule

// File: tb/tb_leaf_label_fifo.sv
// Directed self-checking bench for leaf_label_fifo (default parameters).
module tb_leaf_label_fifo;
  import dtree_pkg::*;

  localparam int TW = DEF_TS_WIDTH;
  localparam int LBW = DEF_LABEL_WIDTH;

  logic            clk = 1'b0;
  logic            reset;
  logic [LW-1:0]   level;
  logic [LW-1:0]   path;
  logic            in_valid;
  logic            cfg_we;
  leaf_idx_t       cfg_addr;
  logic [LBW-1:0]  cfg_label;
  logic            m_valid;
  logic            m_ready;
  logic [LBW-1:0]  m_label;
  logic [TW-1:0]   m_timestamp;
  logic [7:0]      drop_count;
  logic            overflow;
`ifdef CLASS_COUNT_EN
  logic [LBW-1:0]  cnt_sel;
  logic [TW-1:0]   cnt_value;
`endif

  int compared = 0;
  int mismatched = 0;
  int unsigned cycleCount = 0;
  logic [TW-1:0] expTs [16];

  always #5 clk = ~clk;

  // Independent cycle count since reset release; timestamps are this modulo 2**TW.
  always @(posedge clk) begin
    if (reset) cycleCount <= 0;
    else cycleCount <= cycleCount + 1;
  end

  leaf_label_fifo dut (
    .clk         (clk),
    .reset       (reset),
`ifdef CLASS_COUNT_EN
    .cnt_sel     (cnt_sel),
    .cnt_value   (cnt_value),
`endif
    .level       (level),
    .path        (path),
    .in_valid    (in_valid),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_label   (cfg_label),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_label     (m_label),
    .m_timestamp (m_timestamp),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic writeLabel(input leaf_idx_t idx, input logic [LBW-1:0] lab);
    cfg_we = 1'b1;
    cfg_addr = idx;
    cfg_label = lab;
    tick();
    cfg_we = 1'b0;
  endtask

  // One-cycle in_valid pulse; returns the timestamp the event should carry.
  task automatic applyStimulus(input leaf_idx_t idx, output logic [TW-1:0] ts);
    level = idx[2*LW-1:LW];
    path = idx[LW-1:0];
    in_valid = 1'b1;
    ts = TW'(cycleCount % (32'd1 << TW));
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] tsTmp;
    level = '0;
    path = '0;
    cfg_addr = '0;
    cfg_label = '0;
`ifdef CLASS_COUNT_EN
    cnt_sel = '0;
`endif
    applyReset();
    checkOutput("reset m_valid", 32'(m_valid), 0);
    checkOutput("reset m_label", 32'(m_label), 0);
    checkOutput("reset m_timestamp", 32'(m_timestamp), 0);
    checkOutput("reset drop_count", 32'(drop_count), 0);
    checkOutput("reset overflow", 32'(overflow), 0);

    // Basic latency: event at ts=5 appears two cycles later
    writeLabel(4'h6, 4'hA);
    for (int g = 0; g < 20 && cycleCount != 5; g++) tick();
    applyStimulus(4'h6, tsTmp);
    checkOutput("t1 no valid at T+1", 32'(m_valid), 0);
    tick();
    checkOutput("t1 valid at T+2", 32'(m_valid), 1);
    checkOutput("t1 label", 32'(m_label), 32'hA);
    checkOutput("t1 timestamp", 32'(m_timestamp), 5);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("t1 popped", 32'(m_valid), 0);

    for (int e = 0; e < 16; e++) writeLabel(leaf_idx_t'(e), LBW'(15 - e));

    // Overfill by one
    for (int i = 0; i < 9; i++) applyStimulus(leaf_idx_t'(i), expTs[i]);
    tick();
    tick();
    checkOutput("t2 drop_count", 32'(drop_count), 1);
    checkOutput("t2 overflow", 32'(overflow), 1);
    tick();
    checkOutput("t2 head stable label", 32'(m_label), 32'hF);
    checkOutput("t2 head stable ts", 32'(m_timestamp), 32'(expTs[0]));
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t2 drain label %0d", i), 32'(m_label), 32'(15 - i));
      checkOutput($sformatf("t2 drain ts %0d", i), 32'(m_timestamp), 32'(expTs[i]));
      tick();
    end
    m_ready = 1'b0;
    checkOutput("t2 empty after drain", 32'(m_valid), 0);

    // Full FIFO, push and pop on the same edge
    for (int i = 0; i < 8; i++) applyStimulus(leaf_idx_t'(i), expTs[i]);
    tick();
    tick();
    applyStimulus(4'hC, expTs[8]);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("t3 no new drop", 32'(drop_count), 1);
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("t3 valid %0d", k), 32'(m_valid), 1);
      checkOutput($sformatf("t3 label %0d", k), 32'(m_label), (k < 8) ? 32'(15 - k) : 32'd3);
      checkOutput($sformatf("t3 ts %0d", k), 32'(m_timestamp), 32'(expTs[k]));
      tick();
    end
    m_ready = 1'b0;
    checkOutput("t3 empty after 8", 32'(m_valid), 0);

    // Table write colliding with stage-2 read
    writeLabel(4'h3, 4'h7);
    applyStimulus(4'h3, expTs[0]);
    cfg_we = 1'b1;
    cfg_addr = 4'h3;
    cfg_label = 4'h3;
    tick();
    cfg_we = 1'b0;
    applyStimulus(4'h3, expTs[1]);
    tick();
    tick();
    checkOutput("t4 old label", 32'(m_label), 7);
    checkOutput("t4 old ts", 32'(m_timestamp), 32'(expTs[0]));
    m_ready = 1'b1;
    tick();
    checkOutput("t4 new label", 32'(m_label), 3);
    checkOutput("t4 new ts", 32'(m_timestamp), 32'(expTs[1]));
    tick();
    m_ready = 1'b0;
    checkOutput("t4 empty", 32'(m_valid), 0);

    // Timestamp wrap: cycle 65538 -> timestamp 2
    for (int g = 0; g < 70000 && cycleCount != 65538; g++) tick();
    applyStimulus(4'h5, tsTmp);
    tick();
    checkOutput("t5 wrap valid", 32'(m_valid), 1);
    checkOutput("t5 wrap label", 32'(m_label), 32'hA);
    checkOutput("t5 wrap ts", 32'(m_timestamp), 2);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // 108 back-to-back events: 8 queued, 100 dropped on top of the earlier 1
    level = '0;
    path = '0;
    in_valid = 1'b1;
    repeat (108) tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("t5 drops 101", 32'(drop_count), 101);
    in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("t5 drops saturate", 32'(drop_count), 32'hFF);
    checkOutput("t5 overflow", 32'(overflow), 1);

    // Reset with a full FIFO and an event in flight
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst mid m_valid", 32'(m_valid), 0);
    checkOutput("rst mid drop_count", 32'(drop_count), 0);
    checkOutput("rst mid overflow", 32'(overflow), 0);
    tick();
    tick();
    checkOutput("rst mid inflight lost", 32'(m_valid), 0);

`ifdef CLASS_COUNT_EN
    applyReset();
    m_ready = 1'b1;
    writeLabel(4'h1, 4'h2);
    writeLabel(4'h2, 4'h5);
    for (int i = 0; i < 4; i++) applyStimulus(4'h1, expTs[i]);
    applyStimulus(4'h2, expTs[4]);
    repeat (3) tick();
    cnt_sel = 4'h2;
    tick();
    tick();
    checkOutput("t6 count class 2", 32'(cnt_value), 4);
    cnt_sel = 4'h5;
    tick();
    checkOutput("t6 count class 5", 32'(cnt_value), 1);
    applyReset();
    cnt_sel = 4'h2;
    tick();
    checkOutput("t6 count after reset", 32'(cnt_value), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
